// File: rtl/instruction_fetch.sv
// Fetch stage: holds the PC, addresses instruction memory, captures into IF/ID.
// Latency: imem_addr is combinational from pc; the instruction lands in IF/ID one edge later.
// Backpressure: if_ready low with if_valid high freezes pc and IF/ID; halt only drains.
module instruction_fetch #(
  parameter int N        = 32,
  parameter int M        = 256,
  parameter int RESET_PC = 0
) (
  input  logic         clk,
  input  logic         rst,
  output logic [N-1:0] imem_addr,
  input  logic [N-1:0] imem_instr,
  input  logic         redirect_valid,
  input  logic [N-1:0] redirect_target,
  input  logic         halt,
  output logic         if_valid,
  input  logic         if_ready,
  output logic [N-1:0] if_pc,
  output logic [N-1:0] if_instr,
  output logic [N-1:0] fetch_count
);

  // PC is kept N bits wide but always masked to the memory depth, so the
  // upper bits stay zero and imem_addr can be driven straight from it.
  localparam logic [N-1:0] PC_MASK  = N'(M - 1);
  localparam logic [N-1:0] PC_RESET = N'(RESET_PC);
  localparam logic [N-1:0] ONE      = N'(1);

  typedef struct packed {
    logic [N-1:0] pc;
    logic [N-1:0] instr;
  } ifid_t;

  logic [N-1:0] pc;
  ifid_t        ifid;
  logic         ifid_vld;
  logic [N-1:0] count;

  logic take;
  logic fire;

  // Handshake terms: take = decode consumes IF/ID, fire = load a new fetch.
  always_comb begin
    take = ifid_vld & if_ready;
    fire = ~halt & (~ifid_vld | if_ready);
  end

  // PC and IF/ID update; reset beats redirect beats fetch beats hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= PC_RESET;
      ifid     <= '0;
      ifid_vld <= 1'b0;
      count    <= '0;
    end else if (redirect_valid) begin
      // Wrong-path instruction is dropped even if decode is stalled on it.
      pc       <= redirect_target & PC_MASK;
      ifid_vld <= 1'b0;
    end else if (fire) begin
      ifid.pc    <= pc;
      ifid.instr <= imem_instr;
      ifid_vld   <= 1'b1;
      pc         <= (pc + ONE) & PC_MASK;
      if (count != '1) begin
        count <= count + ONE;
      end
    end else if (take) begin
      // Halted: let decode drain the held instruction, then go empty.
      ifid_vld <= 1'b0;
    end
  end

  // Output mapping.
  always_comb begin
    imem_addr   = pc;
    if_valid    = ifid_vld;
    if_pc       = ifid.pc;
    if_instr    = ifid.instr;
    fetch_count = count;
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed vector table, wrap/saturation sequence
// on a narrow instance, and randomized traffic against a behavioural model.
module tb_instruction_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: N=32, M=256, RESET_PC=0
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halt;
  logic        if_ready;
  logic [31:0] imem_addr, imem_instr, if_pc, if_instr, fetch_count;
  logic        if_valid;

  // Narrow instance: N=8, M=256, RESET_PC=254 (wrap and saturation)
  logic        redirect_valid_w;
  logic [7:0]  redirect_target_w;
  logic        halt_w;
  logic        if_ready_w;
  logic [7:0]  imem_addr_w, imem_instr_w, if_pc_w, if_instr_w, fetch_count_w;
  logic        if_valid_w;

  logic [31:0] mem [256];

  assign imem_instr   = mem[imem_addr[7:0]];
  assign imem_instr_w = imem_addr_w ^ 8'h5A;

  instruction_fetch #(.N(32), .M(256), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .halt(halt),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_instr(if_instr), .fetch_count(fetch_count)
  );

  instruction_fetch #(.N(8), .M(256), .RESET_PC(254)) dut_w (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr_w), .imem_instr(imem_instr_w),
    .redirect_valid(redirect_valid_w), .redirect_target(redirect_target_w),
    .halt(halt_w),
    .if_valid(if_valid_w), .if_ready(if_ready_w),
    .if_pc(if_pc_w), .if_instr(if_instr_w), .fetch_count(fetch_count_w)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word(input int i);
    if (i == 0)      return 32'h0020_8133;
    else if (i == 1) return 32'h4020_8233;
    else             return {16'hC0DE, 16'(i)};
  endfunction

  typedef struct {
    logic        r;
    logic        rv;
    logic [31:0] rt;
    logic        h;
    logic        rdy;
    logic        v;
    int          pc;
    logic [31:0] ins;
    int          addr;
    int          cnt;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic rv, input logic [31:0] rt,
                              input logic h, input logic rdy, input logic v,
                              input int pc, input logic [31:0] ins, input int addr,
                              input int cnt);
    vec_t t;
    t.r = r; t.rv = rv; t.rt = rt; t.h = h; t.rdy = rdy;
    t.v = v; t.pc = pc; t.ins = ins; t.addr = addr; t.cnt = cnt;
    return t;
  endfunction

  vec_t vecs [28];

  // Behavioural model state
  int          m_pc, m_ipc, m_cnt;
  bit          m_v;
  logic [31:0] m_ins;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = word(i);

    rst = 1'b1; redirect_valid = 1'b0; redirect_target = '0; halt = 1'b0; if_ready = 1'b0;
    redirect_valid_w = 1'b0; redirect_target_w = '0; halt_w = 1'b0; if_ready_w = 1'b1;

    //             r  rv rt      h  rdy  v  pc  instr        addr cnt
    vecs[0]  = mk(1, 0, 0,      0, 1,   0, 0,  32'h0,       0,   0);
    vecs[1]  = mk(0, 0, 0,      0, 1,   1, 0,  word(0),     1,   1);
    vecs[2]  = mk(0, 0, 0,      0, 1,   1, 1,  word(1),     2,   2);
    vecs[3]  = mk(0, 0, 0,      0, 1,   1, 2,  word(2),     3,   3);
    vecs[4]  = mk(0, 0, 0,      0, 1,   1, 3,  word(3),     4,   4);
    vecs[5]  = mk(0, 0, 0,      0, 0,   1, 3,  word(3),     4,   4);
    vecs[6]  = mk(0, 0, 0,      0, 0,   1, 3,  word(3),     4,   4);
    vecs[7]  = mk(0, 0, 0,      0, 0,   1, 3,  word(3),     4,   4);
    vecs[8]  = mk(0, 0, 0,      0, 0,   1, 3,  word(3),     4,   4);
    vecs[9]  = mk(0, 0, 0,      0, 1,   1, 4,  word(4),     5,   5);
    vecs[10] = mk(0, 0, 0,      0, 0,   1, 4,  word(4),     5,   5);
    vecs[11] = mk(0, 1, 2,      0, 0,   0, 4,  word(4),     2,   5);
    vecs[12] = mk(0, 0, 0,      0, 0,   1, 2,  word(2),     3,   6);
    vecs[13] = mk(0, 0, 0,      0, 1,   1, 3,  word(3),     4,   7);
    vecs[14] = mk(0, 1, 32'h105,0, 1,   0, 3,  word(3),     5,   7);
    vecs[15] = mk(0, 0, 0,      0, 1,   1, 5,  word(5),     6,   8);
    vecs[16] = mk(0, 0, 0,      1, 1,   0, 5,  word(5),     6,   8);
    vecs[17] = mk(0, 0, 0,      1, 1,   0, 5,  word(5),     6,   8);
    vecs[18] = mk(0, 0, 0,      0, 1,   1, 6,  word(6),     7,   9);
    vecs[19] = mk(0, 0, 0,      1, 0,   1, 6,  word(6),     7,   9);
    vecs[20] = mk(0, 0, 0,      1, 1,   0, 6,  word(6),     7,   9);
    vecs[21] = mk(0, 0, 0,      0, 0,   1, 7,  word(7),     8,   10);
    vecs[22] = mk(0, 1, 20,     1, 0,   0, 7,  word(7),     20,  10);
    vecs[23] = mk(0, 0, 0,      0, 1,   1, 20, word(20),    21,  11);
    vecs[24] = mk(0, 1, 9,      0, 1,   0, 20, word(20),    9,   11);
    vecs[25] = mk(0, 0, 0,      0, 0,   1, 9,  word(9),     10,  12);
    vecs[26] = mk(1, 1, 7,      0, 0,   0, 0,  32'h0,       0,   0);
    vecs[27] = mk(0, 0, 0,      0, 1,   1, 0,  word(0),     1,   1);

    // Directed table
    for (int i = 0; i < 28; i++) begin
      rst = vecs[i].r; redirect_valid = vecs[i].rv; redirect_target = vecs[i].rt;
      halt = vecs[i].h; if_ready = vecs[i].rdy;
      tick();
      check($sformatf("row%0d if_valid", i),    32'(if_valid), 32'(vecs[i].v));
      check($sformatf("row%0d if_pc", i),       if_pc, 32'(vecs[i].pc));
      check($sformatf("row%0d if_instr", i),    if_instr, vecs[i].ins);
      check($sformatf("row%0d imem_addr", i),   imem_addr, 32'(vecs[i].addr));
      check($sformatf("row%0d fetch_count", i), fetch_count, 32'(vecs[i].cnt));
    end

    // Wrap from RESET_PC=254 and counter saturation on the narrow instance
    rst = 1'b1; redirect_valid = 1'b0; halt = 1'b1; if_ready = 1'b0;
    tick();
    rst = 1'b0;
    check("wrap reset valid", 32'(if_valid_w), 32'd0);
    check("wrap reset addr",  32'(imem_addr_w), 32'd254);
    check("wrap reset count", 32'(fetch_count_w), 32'd0);
    for (int k = 0; k < 4; k++) begin
      logic [7:0] epc;
      epc = 8'(254 + k);
      tick();
      check($sformatf("wrap%0d valid", k), 32'(if_valid_w), 32'd1);
      check($sformatf("wrap%0d pc", k),    32'(if_pc_w), 32'(epc));
      check($sformatf("wrap%0d instr", k), 32'(if_instr_w), 32'(epc ^ 8'h5A));
    end
    check("wrap count", 32'(fetch_count_w), 32'd4);
    repeat (300) tick();
    check("sat count", 32'(fetch_count_w), 32'd255);
    check("sat valid", 32'(if_valid_w), 32'd1);
    check("sat pc",    32'(if_pc_w), 32'((254 + 304 - 1) % 256));

    // Randomized traffic against the behavioural model
    rst = 1'b1; tick();
    m_pc = 0; m_ipc = 0; m_ins = '0; m_v = 0; m_cnt = 0;
    for (int c = 0; c < 1500; c++) begin
      rst             = ($urandom_range(0, 99) == 0);
      redirect_valid  = ($urandom_range(0, 7) == 0);
      redirect_target = $urandom();
      halt            = ($urandom_range(0, 3) == 0);
      if_ready        = $urandom_range(0, 1);
      if (rst) begin
        m_pc = 0; m_ipc = 0; m_ins = '0; m_v = 0; m_cnt = 0;
      end else if (redirect_valid) begin
        m_pc = int'(redirect_target % 256);
        m_v  = 0;
      end else if (!halt && (!m_v || if_ready)) begin
        m_ins = mem[m_pc];
        m_ipc = m_pc;
        m_v   = 1;
        m_pc  = (m_pc + 1) % 256;
        m_cnt = m_cnt + 1;
      end else if (m_v && if_ready) begin
        m_v = 0;
      end
      tick();
      check($sformatf("rnd%0d if_valid", c),    32'(if_valid), 32'(m_v));
      check($sformatf("rnd%0d imem_addr", c),   imem_addr, 32'(m_pc));
      check($sformatf("rnd%0d if_pc", c),       if_pc, 32'(m_ipc));
      check($sformatf("rnd%0d if_instr", c),    if_instr, m_ins);
      check($sformatf("rnd%0d fetch_count", c), fetch_count, 32'(m_cnt));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage directly upstream of the word-indexed, combinational-read instruction memory.
- Holds the program counter and drives the memory address.
- Captures the returned instruction into an IF/ID register with a valid/ready handshake toward decode.
- Accepts branch redirects from execute. Targets are instruction indices, not byte offsets; no shift is applied.

Parameters:
- N, 32, data/address width (instruction width, PC width)
- M, 256, instruction memory depth in words; power of two, >= 2
- RESET_PC, 0, PC value after reset; must be < M

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- imem_addr  output  N  word address to instruction memory; equals PC combinationally
- imem_instr  input  N  instruction returned by memory for imem_addr in the same cycle
- redirect_valid  input  1  branch/jump taken; load redirect_target
- redirect_target  input  N  new PC, instruction index
- halt  input  1  level; while high, no new fetches are issued
- if_valid  output  1  IF/ID register holds a valid instruction
- if_ready  input  1  decode accepts IF/ID contents this cycle
- if_pc  output  N  PC of the instruction in IF/ID
- if_instr  output  N  instruction in IF/ID
- fetch_count  output  N  number of instructions loaded into IF/ID since reset; saturating

Behaviour:
- Reset (rst=1 at a rising edge) sets:
  - pc=RESET_PC
  - if_valid=0, if_pc=0, if_instr=0
  - fetch_count=0
- Reset has priority over everything and may be asserted mid-stall or mid-redirect; the cycle after reset is always a clean state.
- imem_addr = pc, combinational, no register. Fetch-to-IF/ID latency is 1 cycle.
- Define:
  - take = if_valid & if_ready
  - fire = ~halt & (~if_valid | if_ready)
- Priority order per edge: rst > redirect_valid > fire > hold.
- Redirect (redirect_valid=1):
  - pc <= redirect_target mod M, using the low log2(M) bits; upper bits are ignored.
  - if_valid <= 0. This flushes the wrong-path instruction even if decode is not ready.
  - No capture happens this cycle. fetch_count is unchanged.
  - Redirect overrides both halt and stall.
- Fire without redirect:
  - if_instr <= imem_instr, if_pc <= pc, if_valid <= 1.
  - pc <= pc+1, wrapping M-1 -> 0.
  - fetch_count <= fetch_count+1, saturating at all-ones.
- No fire, no redirect:
  - pc holds.
  - If take, then if_valid <= 0 (drain under halt); otherwise if_valid, if_pc and if_instr hold.
- Stall (if_valid=1, if_ready=0):
  - IF/ID contents stable and pc stable for the whole stall.
  - No instruction is lost or duplicated.
- Back-to-back: with if_ready held at 1 and halt=0, one instruction per cycle at sequential PCs.
- halt rising while if_valid=1: the held instruction is still delivered once if_ready=1; then if_valid=0 until halt falls.
- halt falling: fetch resumes at the held pc on the next edge.
- Simultaneous redirect and take: decode consumes the current IF/ID instruction; the register still becomes invalid; pc takes the target.
- Outputs are undefined only on the memory side: if_instr reflects whatever imem_instr provides. This block performs no decoding.

Test Plan:
1. Reset then if_ready=1, halt=0; memory holds 0x00208133 at 0 and 0x40208233 at 1.
   - Edge 1: if_valid=1, if_pc=0, if_instr=0x00208133.
   - Edge 2: if_pc=1, if_instr=0x40208233.
   - fetch_count=2.
2. Stall: with if_valid=1 at if_pc=3, hold if_ready=0 for 4 cycles.
   - if_pc=3 and if_instr stay constant; imem_addr stays at 4; fetch_count is unchanged.
   - Release: next edge if_pc=4.
3. Redirect at pc=5, redirect_target=2, if_ready=0.
   - Next edge: if_valid=0, pc=2.
   - Following edge: if_pc=2.
   - The flushed instruction is never seen with if_valid=1.
4. Wrap/truncate, M=256:
   - RESET_PC=254 with free flow gives if_pc sequence 254, 255, 0, 1.
   - redirect_target=0x105 gives pc=5.
5. Halt: halt=1 with if_valid=1 and if_ready=1.
   - Next edge: if_valid=0, pc frozen.
   - Deassert halt: fetch resumes at the frozen pc with no gap or duplicate.
6. Mid-operation reset: assert rst during a stall with a concurrent redirect_valid=1 to target 7.
   - Next edge: pc=RESET_PC, if_valid=0, fetch_count=0; the redirect is ignored.
